imem_loader: RTL and testbench

Program loader that writes into the IF stage's instruction memory through its write port (W_Ins/WE) while holding the core in reset. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes each word to consecutive word addresses starting at ADDR_BASE, then releases the core so the IF stage fetches from the loaded image.

---
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Loads a program image into the IF stage's instruction memory through its
// write port while holding the core in reset. Bytes arrive on a valid/ready
// stream and are packed big-endian into 32-bit words. Each word is written
// to the next word address, starting at ADDR_BASE. When the last word has
// been written, CoreRST is released so the core fetches the new image.
//
// Ports:
//   CLK       clock, rising edge
//   RST       synchronous active-high reset
//   Start     single-cycle load request (only honoured in IDLE or DONE)
//   Len       number of words to load, sampled with Start
//   In_Valid  byte-stream valid
//   In_Data   byte-stream data
//   In_Ready  loader accepts a byte this cycle
//   W_Addr    IMem byte address of the write
//   W_Ins     instruction word being written
//   WE        IMem write enable
//   Busy      load in progress
//   Done      last load completed (sticky until next Start / reset)
//   Err       last Start was rejected (sticky until next Start / reset)
//   CoreRST   core reset hold; low only once a load has completed
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [15:0] Len,
    input  logic        In_Valid,
    input  logic [7:0]  In_Data,
    output logic        In_Ready,
    output logic [31:0] W_Addr,
    output logic [31:0] W_Ins,
    output logic        WE,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic        CoreRST
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One extra bit so a Len of 65535 compares correctly against any limit.
    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state_reg,    state_next;
    logic [15:0] len_reg,      len_next;
    logic [15:0] index_reg,    index_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [31:0] w_ins_reg,    w_ins_next;
    logic [31:0] w_addr_reg,   w_addr_next;
    logic        err_reg,      err_next;
    logic        we_reg,       we_next;
    logic        in_ready_reg, in_ready_next;
    logic        busy_reg,     busy_next;
    logic        done_reg,     done_next;
    logic        core_rst_reg, core_rst_next;

    logic        accept;
    logic [31:0] shifted_word;

    assign accept = In_Valid && in_ready_reg && (state_reg == RECV);

    // Big-endian packing: every accepted byte pushes the previous ones one
    // lane up, so after four bytes the first one sits in [31:24].
    assign shifted_word[7:0] = In_Data;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_lane
            assign shifted_word[gi*8 +: 8] = w_ins_reg[(gi-1)*8 +: 8];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            index_reg    <= '0;
            byte_cnt_reg <= '0;
            w_ins_reg    <= '0;
            w_addr_reg   <= ADDR_BASE;
            err_reg      <= 1'b0;
            we_reg       <= 1'b0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            core_rst_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            index_reg    <= index_next;
            byte_cnt_reg <= byte_cnt_next;
            w_ins_reg    <= w_ins_next;
            w_addr_reg   <= w_addr_next;
            err_reg      <= err_next;
            we_reg       <= we_next;
            in_ready_reg <= in_ready_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            core_rst_reg <= core_rst_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        index_next    = index_reg;
        byte_cnt_next = byte_cnt_reg;
        w_ins_next    = w_ins_reg;
        err_next      = err_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (Start) begin
                    byte_cnt_next = '0;
                    index_next    = '0;
                    if (Len == 16'd0) begin
                        state_next = DONE;
                        err_next   = 1'b0;
                    end else if ({1'b0, Len} > MAX_W) begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                    end else begin
                        state_next = RECV;
                        len_next   = Len;
                        err_next   = 1'b0;
                    end
                end
            end
            RECV: begin
                if (accept) begin
                    w_ins_next    = shifted_word;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                index_next    = index_reg + 16'd1;
                byte_cnt_next = '0;
                if ((index_reg + 16'd1) == len_reg) begin
                    state_next = DONE;
                end else begin
                    state_next = RECV;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies, so
        // e.g. In_Ready falls in the same cycle the FSM enters WRITE.
        we_next       = (state_next == WRITE);
        in_ready_next = (state_next == RECV);
        busy_next     = (state_next == RECV) || (state_next == WRITE);
        done_next     = (state_next == DONE);
        core_rst_next = (state_next != DONE);
        // The address tracks the word index; it only changes on the WRITE
        // edge, so it is stable for the whole cycle WE is high.
        w_addr_next   = ADDR_BASE + {14'b0, index_next, 2'b00};
    end

    assign In_Ready = in_ready_reg;
    assign W_Addr   = w_addr_reg;
    assign W_Ins    = w_ins_reg;
    assign WE       = we_reg;
    assign Busy     = busy_reg;
    assign Done     = done_reg;
    assign Err      = err_reg;
    assign CoreRST  = core_rst_reg;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic [15:0] Len;
    logic        In_Valid;
    logic [7:0]  In_Data;
    logic        In_Ready;
    logic [31:0] W_Addr;
    logic [31:0] W_Ins;
    logic        WE;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic        CoreRST;

    int checks = 0;
    int errors = 0;

    // Expected writes: {address, word}
    logic [63:0] exp_q[$];

    imem_loader #(.ADDR_BASE(32'h0000_0000), .MAX_WORDS(1024)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Len(Len),
        .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(In_Ready),
        .W_Addr(W_Addr), .W_Ins(W_Ins), .WE(WE), .Busy(Busy),
        .Done(Done), .Err(Err), .CoreRST(CoreRST)
    );

    always #5 CLK = ~CLK;

    // Scoreboard side: every write pulse is popped and compared.
    always @(negedge CLK) begin
        if (WE === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_we addr=%h ins=%h expected no write", W_Addr, W_Ins);
            end
            if (exp_q.size() > 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                checks++;
                assert ({W_Addr, W_Ins} === e) else begin
                    errors++;
                    $error("FAIL write addr=%h ins=%h expected addr=%h ins=%h",
                           W_Addr, W_Ins, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one byte and waits for it to be taken; In_Valid stays high.
    task automatic send_byte(input logic [7:0] b);
        int n;
        In_Valid = 1'b1;
        In_Data  = b;
        n = 0;
        while (In_Ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        assert (In_Ready === 1'b1) else begin
            errors++;
            $error("FAIL ready_timeout byte=%h observed=%b expected=1", b, In_Ready);
        end
        step();
    endtask

    task automatic pulse_start(input logic [15:0] l);
        Start = 1'b1;
        Len   = l;
        step();
        Start = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check1({tag, "_we"}, WE, 1'b0);
        check32({tag, "_ins"}, W_Ins, 32'h0);
        check32({tag, "_addr"}, W_Addr, 32'h0);
        check1({tag, "_ready"}, In_Ready, 1'b0);
        check1({tag, "_busy"}, Busy, 1'b0);
        check1({tag, "_done"}, Done, 1'b0);
        check1({tag, "_err"}, Err, 1'b0);
        check1({tag, "_corerst"}, CoreRST, 1'b1);
    endtask

    initial begin
        RST = 1'b1; Start = 1'b0; Len = '0; In_Valid = 1'b0; In_Data = '0;
        step(); step();
        check_reset_state("reset");
        RST = 1'b0;
        step();

        // 1: two words, stream held valid
        exp_q.push_back({32'h0, 32'h2008_0005});
        exp_q.push_back({32'h4, 32'h0000_000C});
        pulse_start(16'd2);
        check1("t1_busy", Busy, 1'b1);
        check1("t1_ready", In_Ready, 1'b1);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        check1("t1_we1", WE, 1'b1);
        check1("t1_ready_in_write", In_Ready, 1'b0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
        In_Valid = 1'b0;
        check1("t1_we2", WE, 1'b1);
        check1("t1_done_early", Done, 1'b0);
        step();
        check1("t1_done", Done, 1'b1);
        check1("t1_corerst", CoreRST, 1'b0);
        check1("t1_we_off", WE, 1'b0);
        check1("t1_ready_done", In_Ready, 1'b0);

        // 2: same load with a 3-cycle stall after byte 2
        exp_q.push_back({32'h0, 32'h2008_0005});
        exp_q.push_back({32'h4, 32'h0000_000C});
        pulse_start(16'd2);
        check1("t2_corerst", CoreRST, 1'b1);
        check1("t2_done_clr", Done, 1'b0);
        send_byte(8'h20); send_byte(8'h08);
        In_Valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check1("t2_stall_we", WE, 1'b0);
            step();
        end
        send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
        In_Valid = 1'b0;
        step();
        check1("t2_done", Done, 1'b1);

        // 3: Len = 0 completes immediately
        pulse_start(16'd0);
        check1("t3_done", Done, 1'b1);
        check1("t3_err", Err, 1'b0);
        check1("t3_corerst", CoreRST, 1'b0);
        check1("t3_we", WE, 1'b0);

        // 4: Len above capacity is rejected; bytes offered are never taken
        pulse_start(16'd1025);
        In_Valid = 1'b1; In_Data = 8'h55;
        check1("t4_err", Err, 1'b1);
        check1("t4_done", Done, 1'b0);
        check1("t4_corerst", CoreRST, 1'b1);
        check1("t4_busy", Busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check1("t4_ready", In_Ready, 1'b0);
            step();
        end
        In_Valid = 1'b0;

        // 5: reset in the middle of word 1 discards the partial word
        exp_q.push_back({32'h0, 32'h0102_0304});
        pulse_start(16'd3);
        check1("t5_err_clr", Err, 1'b0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05); send_byte(8'h06);
        In_Valid = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_reset_state("t5_rst");
        exp_q.push_back({32'h0, 32'hAABB_CCDD});
        pulse_start(16'd1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        In_Valid = 1'b0;
        step();
        check1("t5_done", Done, 1'b1);

        // 6: Start during RECV is ignored, Len stays at 2
        exp_q.push_back({32'h0, 32'h1122_3344});
        exp_q.push_back({32'h4, 32'h5566_7788});
        pulse_start(16'd2);
        send_byte(8'h11); send_byte(8'h22);
        In_Valid = 1'b0;
        pulse_start(16'd1);
        check1("t6_busy_after_start", Busy, 1'b1);
        send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        In_Valid = 1'b0;
        step();
        check1("t6_done", Done, 1'b1);
        exp_q.push_back({32'h0, 32'hDEAD_BEEF});
        pulse_start(16'd1);
        check1("t6_corerst_reassert", CoreRST, 1'b1);
        check32("t6_addr_restart", W_Addr, 32'h0);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        In_Valid = 1'b0;
        step();
        check1("t6_done2", Done, 1'b1);
        check1("t6_corerst_rel", CoreRST, 1'b0);
        step();

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL missing_writes observed=%0d pending expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
